ahb_bus_arbiter: RTL and testbench

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

---
 rtl/ahb_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// AHB-lite bus arbiter: round-robin grant of one subordinate port among NUM_MGR managers.
// The grant is held for a whole burst, and the owner's address and data phases are muxed out.
module ahb_bus_arbiter #(
    parameter int NUM_MGR    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          HRESET,
    input  logic [NUM_MGR-1:0]            m_req,
    input  logic [2*NUM_MGR-1:0]          m_htrans,
    input  logic [ADDR_WIDTH*NUM_MGR-1:0] m_haddr,
    input  logic [3*NUM_MGR-1:0]          m_hburst,
    input  logic [3*NUM_MGR-1:0]          m_hsize,
    input  logic [NUM_MGR-1:0]            m_hwrite,
    input  logic [DATA_WIDTH*NUM_MGR-1:0] m_hwdata,
    output logic [NUM_MGR-1:0]            m_grant,
    output logic [1:0]                    HTRANS,
    output logic [ADDR_WIDTH-1:0]         HADDR,
    output logic [2:0]                    HBURST,
    output logic [2:0]                    HSIZE,
    output logic                          HWRITE,
    output logic [DATA_WIDTH-1:0]         HWDATA,
    input  logic                          HREADY,
    input  logic                          HRESP,
    output logic [2:0]                    data_owner
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ARB = 2'd0, OWN = 2'd1, BURST = 2'd2} state_t;

    state_t                 state, state_nxt;
    logic [NUM_MGR-1:0]     grant_nxt;
    logic [2:0]             last_owner, last_owner_nxt, winner;
    logic                   win_found;
    logic [4:0]             beat_cnt, beat_cnt_nxt, burst_len, burst_len_nxt, nonseq_len;
    logic                   is_incr, is_incr_nxt;
    logic                   arb_en;
    logic                   active, owner_req, beat, drop_grant;
    logic [1:0]             own_htrans;
    logic [ADDR_WIDTH-1:0]  own_haddr;
    logic [2:0]             own_hburst, own_hsize;
    logic                   own_hwrite;

    // Round-robin search: first requester at distance 1..NUM_MGR after last_owner.
    always_comb begin
        winner    = last_owner;
        win_found = 1'b0;
        for (int d = 1; d <= NUM_MGR; d++) begin
            for (int j = 0; j < NUM_MGR; j++) begin
                if (!win_found && m_req[j] &&
                    (int'(last_owner) + d == j || int'(last_owner) + d == j + NUM_MGR)) begin
                    winner    = 3'(j);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        own_htrans = TR_IDLE;
        own_haddr  = '0;
        own_hburst = '0;
        own_hsize  = '0;
        own_hwrite = 1'b0;
        HWDATA     = '0;
        for (int i = 0; i < NUM_MGR; i++) begin
            if (last_owner == 3'(i)) begin
                owner_req  = m_req[i];
                own_htrans = m_htrans[2*i +: 2];
                own_haddr  = m_haddr[ADDR_WIDTH*i +: ADDR_WIDTH];
                own_hburst = m_hburst[3*i +: 3];
                own_hsize  = m_hsize[3*i +: 3];
                own_hwrite = m_hwrite[i];
            end
            if (data_owner == 3'(i)) HWDATA = m_hwdata[DATA_WIDTH*i +: DATA_WIDTH];
        end
    end

    assign active = |m_grant;
    assign HTRANS = active ? own_htrans : TR_IDLE;
    assign HADDR  = active ? own_haddr : '0;
    assign HBURST = active ? own_hburst : 3'd0;
    assign HSIZE  = active ? own_hsize : 3'd0;
    assign HWRITE = active & own_hwrite;
    assign beat   = HREADY & HTRANS[1];

    // INCR (1) shares the 16-beat cap with INCR16/WRAP16.
    always_comb begin
        case (HBURST)
            3'd0:       nonseq_len = 5'd1;
            3'd2, 3'd3: nonseq_len = 5'd4;
            3'd4, 3'd5: nonseq_len = 5'd8;
            default:    nonseq_len = 5'd16;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = m_grant;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        burst_len_nxt  = burst_len;
        is_incr_nxt    = is_incr;
        drop_grant     = 1'b0;
        case (state)
            ARB: begin
                if (arb_en && HREADY && win_found) begin
                    state_nxt      = OWN;
                    last_owner_nxt = winner;
                    beat_cnt_nxt   = '0;
                    for (int j = 0; j < NUM_MGR; j++) grant_nxt[j] = (winner == 3'(j));
                end
            end
            OWN: begin
                if (HREADY) begin
                    if (HRESP) drop_grant = 1'b1;
                    else if (HTRANS == TR_NONSEQ) begin
                        beat_cnt_nxt  = 5'd1;
                        burst_len_nxt = nonseq_len;
                        is_incr_nxt   = (HBURST == 3'd1);
                        if (nonseq_len == 5'd1) drop_grant = 1'b1;
                        else state_nxt = BURST;
                    end else if (!owner_req) drop_grant = 1'b1;
                end
            end
            BURST: begin
                if (HREADY) begin
                    if (HRESP) drop_grant = 1'b1;
                    else if (beat && (beat_cnt + 5'd1 == burst_len)) drop_grant = 1'b1;
                    else if (is_incr && (HTRANS == TR_IDLE || !owner_req)) drop_grant = 1'b1;
                    else if (beat) beat_cnt_nxt = beat_cnt + 5'd1;
                end
            end
            default: drop_grant = 1'b1;
        endcase
        if (drop_grant) begin
            state_nxt    = ARB;
            grant_nxt    = '0;
            beat_cnt_nxt = '0;
        end
    end

    // arb_en holds off the first grant until the second edge after reset release.
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            state      <= ARB;
            m_grant    <= '0;
            last_owner <= 3'(NUM_MGR - 1);
            beat_cnt   <= '0;
            burst_len  <= '0;
            is_incr    <= 1'b0;
            arb_en     <= 1'b0;
            data_owner <= '0;
        end else begin
            state      <= state_nxt;
            m_grant    <= grant_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
            burst_len  <= burst_len_nxt;
            is_incr    <= is_incr_nxt;
            arb_en     <= 1'b1;
            if (HREADY && active) data_owner <= last_owner;
        end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: round-robin vector table, directed burst sequences and a
// randomized run, all checked against a rule-level model of owner and beat counts.
module tb_ahb_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

    logic              clk = 1'b0;
    logic              HRESET;
    logic [N-1:0]      m_req;
    logic [2*N-1:0]    m_htrans;
    logic [AW*N-1:0]   m_haddr;
    logic [3*N-1:0]    m_hburst, m_hsize;
    logic [N-1:0]      m_hwrite;
    logic [DW*N-1:0]   m_hwdata;
    logic [N-1:0]      m_grant;
    logic [1:0]        HTRANS;
    logic [AW-1:0]     HADDR;
    logic [2:0]        HBURST, HSIZE;
    logic              HWRITE;
    logic [DW-1:0]     HWDATA;
    logic              HREADY, HRESP;
    logic [2:0]        data_owner;

    logic [1:0]    tr [N];
    logic [2:0]    bu [N];
    logic [2:0]    sz [N];
    logic          wr [N];
    logic [AW-1:0] ad [N];
    logic [DW-1:0] wd [N];

    int checks = 0;
    int failures = 0;

    // Model state: owner index (-1 = none), beats done/total of the current burst.
    int md_owner, md_last, md_done, md_total, md_downer;
    bit md_started, md_incr, md_en;

    always #5 clk = ~clk;

    always_comb begin
        m_htrans = '0; m_haddr = '0; m_hburst = '0; m_hsize = '0; m_hwrite = '0; m_hwdata = '0;
        for (int i = 0; i < N; i++) begin
            m_htrans[2*i +: 2]   = tr[i];
            m_haddr[AW*i +: AW]  = ad[i];
            m_hburst[3*i +: 3]   = bu[i];
            m_hsize[3*i +: 3]    = sz[i];
            m_hwrite[i]          = wr[i];
            m_hwdata[DW*i +: DW] = wd[i];
        end
    end

    ahb_bus_arbiter #(.NUM_MGR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .HRESET(HRESET), .m_req(m_req), .m_htrans(m_htrans), .m_haddr(m_haddr),
        .m_hburst(m_hburst), .m_hsize(m_hsize), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
        .m_grant(m_grant), .HTRANS(HTRANS), .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .data_owner(data_owner)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int burst_beats(input logic [2:0] hb);
        if (hb == 3'd0) return 1;
        if (hb == 3'd1) return 16;
        return 2 << (int'(hb) / 2);
    endfunction

    task automatic model_reset();
        md_owner = -1; md_last = N - 1; md_done = 0; md_total = 0;
        md_started = 0; md_incr = 0; md_downer = 0; md_en = 0;
    endtask

    // Applies the arbitration rules to the inputs present at this clock edge.
    task automatic model_update();
        int prev;
        int c;
        logic [1:0] t;
        bit acc, rq;
        if (HRESET) begin
            model_reset();
            return;
        end
        prev = md_owner;
        if (md_owner < 0) begin
            if (md_en && HREADY && m_req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (md_last + k) % N;
                    if (md_owner < 0 && m_req[c]) begin
                        md_owner = c; md_last = c; md_started = 0;
                    end
                end
            end
        end else if (HREADY) begin
            t = tr[md_owner];
            rq = m_req[md_owner];
            acc = (t == NONSEQ || t == SEQ);
            if (HRESP) md_owner = -1;
            else if (!md_started) begin
                if (t == NONSEQ) begin
                    md_started = 1; md_done = 1;
                    md_total = burst_beats(bu[md_owner]);
                    md_incr = (bu[md_owner] == 3'd1);
                    if (md_done == md_total) md_owner = -1;
                end else if (!rq) md_owner = -1;
            end else begin
                if (acc) md_done++;
                if (acc && md_done == md_total) md_owner = -1;
                else if (md_incr && (t == IDLE || !rq)) md_owner = -1;
            end
        end
        if (HREADY && prev >= 0) md_downer = prev;
        md_en = 1;
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [1:0] et;
        logic [AW-1:0] ea;
        logic [2:0] eb, es;
        logic ew;
        if (HRESET) model_reset();
        eg = '0; et = IDLE; ea = '0; eb = '0; es = '0; ew = 1'b0;
        if (md_owner >= 0) begin
            eg[md_owner] = 1'b1;
            et = tr[md_owner]; ea = ad[md_owner]; eb = bu[md_owner];
            es = sz[md_owner]; ew = wr[md_owner];
        end
        chk("m_grant", m_grant, eg);
        chk("HTRANS", HTRANS, et);
        chk("HADDR", HADDR, ea);
        chk("HBURST", HBURST, eb);
        chk("HSIZE", HSIZE, es);
        chk("HWRITE", HWRITE, ew);
        chk("HWDATA", HWDATA, wd[md_downer]);
        chk("data_owner", data_owner, 3'(md_downer));
    endtask

    // One clock: compare against the model, then advance the model at the edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic beat(input int m, input logic [1:0] t, input logic rdy, input logic resp,
                        input logic [N-1:0] exp_g, input string tag);
        tr[m] = t; HREADY = rdy; HRESP = resp;
        #1;
        chk(tag, m_grant, exp_g);
        step();
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  exp_grant;
        logic [AW-1:0] exp_addr;
    } rr_vec_t;

    rr_vec_t vecs [9];

    initial begin
        vecs[0] = '{4'b1111, 4'b0001, 32'hA000_0000};
        vecs[1] = '{4'b1111, 4'b0010, 32'hA000_0010};
        vecs[2] = '{4'b1111, 4'b0100, 32'hA000_0020};
        vecs[3] = '{4'b1111, 4'b1000, 32'hA000_0030};
        vecs[4] = '{4'b1111, 4'b0001, 32'hA000_0000};
        vecs[5] = '{4'b1001, 4'b1000, 32'hA000_0030};
        vecs[6] = '{4'b0110, 4'b0010, 32'hA000_0010};
        vecs[7] = '{4'b0001, 4'b0001, 32'hA000_0000};
        vecs[8] = '{4'b1100, 4'b0100, 32'hA000_0020};

        model_reset();
        HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; m_req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            tr[i] = NONSEQ; bu[i] = 3'd0; sz[i] = 3'd2; wr[i] = 1'b1;
            ad[i] = 32'hA000_0000 + 32'(i * 16); wd[i] = 32'hD000_0000 + 32'(i);
        end
        step(); step();
        #1;
        chk("rst_grant", m_grant, 0);
        chk("rst_htrans", HTRANS, IDLE);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_data_owner", data_owner, 0);
        chk("rst_hwdata", HWDATA, wd[0]);
        m_req = '0;
        HRESET = 1'b0;
        step();

        // Single transfers: round-robin order and exactly one idle arbitration cycle.
        for (int v = 0; v < 9; v++) begin
            m_req = vecs[v].req;
            #1;
            chk("rr_arb_grant", m_grant, 0);
            chk("rr_arb_htrans", HTRANS, IDLE);
            step();
            chk("rr_grant", m_grant, vecs[v].exp_grant);
            chk("rr_haddr", HADDR, vecs[v].exp_addr);
            chk("rr_htrans", HTRANS, NONSEQ);
            step();
        end

        // INCR8 on manager 2 with a two-cycle stall; manager 0 waits for the burst end.
        for (int i = 0; i < N; i++) tr[i] = IDLE;
        m_req = 4'b0100; bu[2] = 3'b101;
        beat(2, NONSEQ, 1, 0, 4'b0000, "s2_arb");
        beat(2, NONSEQ, 1, 0, 4'b0100, "s2_b1");
        beat(2, SEQ, 1, 0, 4'b0100, "s2_b2");
        m_req[0] = 1'b1; bu[0] = 3'd0; tr[0] = NONSEQ;
        beat(2, SEQ, 0, 0, 4'b0100, "s2_stall1");
        beat(2, SEQ, 0, 0, 4'b0100, "s2_stall2");
        for (int b = 3; b <= 8; b++) beat(2, SEQ, 1, 0, 4'b0100, "s2_beat");
        m_req[2] = 1'b0;
        beat(2, IDLE, 1, 0, 4'b0000, "s2_gap");
        beat(0, NONSEQ, 1, 0, 4'b0001, "s2_next");
        m_req = '0;

        // WRAP4 on manager 1 with a BUSY that must not count.
        m_req = 4'b0010; bu[1] = 3'b010;
        beat(1, NONSEQ, 1, 0, 4'b0000, "s3_arb");
        beat(1, NONSEQ, 1, 0, 4'b0010, "s3_b1");
        beat(1, BUSY, 1, 0, 4'b0010, "s3_busy");
        for (int b = 2; b <= 4; b++) beat(1, SEQ, 1, 0, 4'b0010, "s3_beat");
        m_req = '0;
        beat(1, IDLE, 1, 0, 4'b0000, "s3_rel");

        // INCR on manager 3, request dropped after five beats.
        m_req = 4'b1000; bu[3] = 3'b001;
        beat(3, NONSEQ, 1, 0, 4'b0000, "s4_arb");
        beat(3, NONSEQ, 1, 0, 4'b1000, "s4_b1");
        for (int b = 2; b <= 5; b++) beat(3, SEQ, 1, 0, 4'b1000, "s4_beat");
        m_req[3] = 1'b0;
        beat(3, BUSY, 1, 0, 4'b1000, "s4_drop");
        tr[3] = IDLE;
        #1;
        chk("s4_rel_htrans", HTRANS, IDLE);
        beat(3, IDLE, 1, 0, 4'b0000, "s4_rel");

        // INCR16 on manager 0 with a two-cycle ERROR response on beat 2.
        m_req = 4'b0001; bu[0] = 3'b111;
        beat(0, NONSEQ, 1, 0, 4'b0000, "s5_arb");
        beat(0, NONSEQ, 1, 0, 4'b0001, "s5_b1");
        beat(0, SEQ, 1, 0, 4'b0001, "s5_b2");
        beat(0, SEQ, 0, 1, 4'b0001, "s5_err1");
        beat(0, SEQ, 1, 1, 4'b0001, "s5_err2");
        m_req = '0;
        tr[0] = IDLE;
        #1;
        chk("s5_abort_htrans", HTRANS, IDLE);
        beat(0, IDLE, 1, 0, 4'b0000, "s5_abort");

        // Reset pulsed during INCR4; manager 0 wins first after release.
        m_req = 4'b0001; bu[0] = 3'b011;
        beat(0, NONSEQ, 1, 0, 4'b0000, "s6_arb");
        beat(0, NONSEQ, 1, 0, 4'b0001, "s6_b1");
        beat(0, SEQ, 1, 0, 4'b0001, "s6_b2");
        #1;
        chk("s6_pre_rst", m_grant, 4'b0001);
        HRESET = 1'b1;
        #1;
        chk("s6_rst_grant", m_grant, 0);
        chk("s6_rst_haddr", HADDR, 0);
        chk("s6_rst_htrans", HTRANS, IDLE);
        model_reset();
        m_req = 4'b1111;
        for (int i = 0; i < N; i++) begin tr[i] = NONSEQ; bu[i] = 3'd0; end
        step(); step();
        HRESET = 1'b0;
        step();
        chk("s6_edge1_grant", m_grant, 0);
        step();
        chk("s6_first_grant", m_grant, 4'b0001);
        m_req = '0;
        step(); step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                r = $urandom_range(0, 99);
                tr[i] = (r < 25) ? IDLE : (r < 35) ? BUSY : (r < 65) ? NONSEQ : SEQ;
                bu[i] = 3'($urandom_range(0, 7));
                sz[i] = 3'($urandom_range(0, 2));
                wr[i] = 1'($urandom_range(0, 1));
                ad[i] = $urandom;
                wd[i] = $urandom;
                if ($urandom_range(0, 7) == 0) m_req[i] = ~m_req[i];
            end
            HREADY = ($urandom_range(0, 3) != 0);
            HRESP  = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
